gelato_inst_buffer: RTL and testbench

//  Per-warp instruction buffer directly downstream of the frontend decode stage.
//  - Accepts decoded instructions tagged by warp and holds them in one FIFO per warp.
//  - Returns per-warp slot credits to the fetch scheduler, so fetch never overruns a FIFO.
//  - Presents one instruction per cycle to the issue stage, chosen by round-robin among eligible warps.
//  - Discards stale in-flight instructions after a per-warp flush (branch/split redirect).

---
 rtl/gelato_pkg.sv | 14 +
 rtl/gelato_ibuffer_rr_arbiter.sv | 32 +++
 rtl/gelato_inst_buffer.sv | 130 +++++++++++++
 tb/tb_gelato_inst_buffer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gelato_pkg.sv
// gelato_pkg: constants and types shared by fetch scheduler, decode and the instruction buffer
//   NUM_WARPS      warps per core
//   IBUF_DEPTH     instruction buffer entries per warp
//   INST_W         decoded instruction width
//   warp_id_t      warp index
//   decoded_inst_t decoded instruction word
package gelato_pkg;
    localparam int NUM_WARPS  = 8;
    localparam int IBUF_DEPTH = 4;
    localparam int INST_W     = 64;
    localparam int WID_W      = $clog2(NUM_WARPS);
    typedef logic [WID_W-1:0]  warp_id_t;
    typedef logic [INST_W-1:0] decoded_inst_t;
endpackage

// File: rtl/gelato_ibuffer_rr_arbiter.sv
// gelato_ibuffer_rr_arbiter: combinational round-robin pick among requesters
//   req  in   N  request vector
//   ptr  in   W  index where the search starts (owned by the parent)
//   gnt  out  N  one-hot grant, zero when nothing requests
//   idx  out  W  encoded grant index
module gelato_ibuffer_rr_arbiter
    import gelato_pkg::*;
#(
    parameter int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx
);
    logic [W-1:0] k;
    // Walk the ring backwards so the last hit is the first requester at or after ptr.
    always_comb begin
        gnt = '0;
        idx = '0;
        k = '0;
        for (int i = N - 1; i >= 0; i--) begin
            k = W'((int'(ptr) + i) % N);
            if (req[k]) begin
                gnt = '0;
                gnt[k] = 1'b1;
                idx = k;
            end
        end
    end
endmodule

// File: rtl/gelato_inst_buffer.sv
// gelato_inst_buffer: per-warp credit-managed instruction FIFOs with round-robin issue
//   clk, rst              clock, synchronous active-high reset
//   rdy                   global enable; low freezes all state and hides out_valid
//   rsv_valid/rsv_warp    fetch reservation of one slot
//   ibuf_space            per-warp credit available
//   dec_valid/warp/inst   decoded instruction arrival
//   flush_valid/warp      discard buffered and in-flight instructions of one warp
//   issue_mask            per-warp issue eligibility
//   out_valid/warp/inst   instruction offered to issue
//   out_ready             issue accepts
module gelato_inst_buffer #(
    parameter int NUM_WARPS = gelato_pkg::NUM_WARPS,
    parameter int DEPTH     = gelato_pkg::IBUF_DEPTH,
    parameter int INST_W    = gelato_pkg::INST_W,
    localparam int WID_W    = $clog2(NUM_WARPS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 rsv_valid,
    input  logic [WID_W-1:0]     rsv_warp,
    output logic [NUM_WARPS-1:0] ibuf_space,
    input  logic                 dec_valid,
    input  logic [WID_W-1:0]     dec_warp,
    input  logic [INST_W-1:0]    dec_inst,
    input  logic                 flush_valid,
    input  logic [WID_W-1:0]     flush_warp,
    input  logic [NUM_WARPS-1:0] issue_mask,
    output logic                 out_valid,
    output logic [WID_W-1:0]     out_warp,
    output logic [INST_W-1:0]    out_inst,
    input  logic                 out_ready
);
    import gelato_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    logic [CNT_W-1:0]     cnt    [NUM_WARPS];
    logic [CNT_W-1:0]     rsv    [NUM_WARPS];
    logic [CNT_W-1:0]     drop   [NUM_WARPS];
    logic [PTR_W-1:0]     rd_ptr [NUM_WARPS];
    logic [PTR_W-1:0]     wr_ptr [NUM_WARPS];
    logic [INST_W-1:0]    mem    [NUM_WARPS][DEPTH];
    logic [WID_W-1:0]     rr_ptr;
    logic [WID_W-1:0]     grant_idx;
    logic [NUM_WARPS-1:0] grant;
    logic [NUM_WARPS-1:0] req;
    logic [NUM_WARPS-1:0] rsv_hit;
    logic [NUM_WARPS-1:0] arr_hit;
    logic [NUM_WARPS-1:0] flush_hit;
    logic [NUM_WARPS-1:0] push;
    logic [NUM_WARPS-1:0] pop;
    logic                 hs;

    // Protocol violations (reserving without credit, arriving without a reservation) are masked here.
    always_comb begin
        ibuf_space = '0;
        req = '0;
        rsv_hit = '0;
        arr_hit = '0;
        flush_hit = '0;
        push = '0;
        pop = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            ibuf_space[w] = ({1'b0, cnt[w]} + {1'b0, rsv[w]}) < (CNT_W + 1)'(DEPTH);
            flush_hit[w] = flush_valid && flush_warp == WID_W'(w);
            req[w] = cnt[w] != '0 && issue_mask[w] && !flush_hit[w];
            rsv_hit[w] = rsv_valid && rsv_warp == WID_W'(w) && ibuf_space[w];
            arr_hit[w] = dec_valid && dec_warp == WID_W'(w) && rsv[w] != '0;
            push[w] = arr_hit[w] && drop[w] == '0 && !flush_hit[w];
            pop[w] = hs && grant[w];
        end
    end

    gelato_ibuffer_rr_arbiter #(.N(NUM_WARPS)) u_arb (
        .req(req),
        .ptr(rr_ptr),
        .gnt(grant),
        .idx(grant_idx)
    );

    assign out_valid = rdy && |grant;
    assign out_warp  = grant_idx;
    assign out_inst  = mem[grant_idx][rd_ptr[grant_idx]];
    assign hs        = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
            for (int w = 0; w < NUM_WARPS; w++) begin
                cnt[w] <= '0;
                rsv[w] <= '0;
                drop[w] <= '0;
                rd_ptr[w] <= '0;
                wr_ptr[w] <= '0;
            end
        end else if (rdy) begin
            if (hs)
                rr_ptr <= grant_idx == WID_W'(NUM_WARPS - 1) ? '0 : grant_idx + WID_W'(1);
            for (int w = 0; w < NUM_WARPS; w++) begin
                rsv[w] <= rsv[w] + CNT_W'(rsv_hit[w]) - CNT_W'(arr_hit[w]);
                if (flush_hit[w]) begin
                    // Every outstanding reservation now belongs to a stale fetch.
                    cnt[w] <= '0;
                    rd_ptr[w] <= wr_ptr[w];
                    drop[w] <= drop[w] + rsv[w] + CNT_W'(rsv_hit[w]) - CNT_W'(arr_hit[w]);
                end else begin
                    if (arr_hit[w] && drop[w] != '0)
                        drop[w] <= drop[w] - CNT_W'(1);
                    if (push[w])
                        wr_ptr[w] <= wr_ptr[w] + PTR_W'(1);
                    if (pop[w])
                        rd_ptr[w] <= rd_ptr[w] + PTR_W'(1);
                    cnt[w] <= cnt[w] + CNT_W'(push[w]) - CNT_W'(pop[w]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rdy && push[dec_warp])
            mem[dec_warp][wr_ptr[dec_warp]] <= dec_inst;
    end

    a_rsv_credit: assert property (@(posedge clk) disable iff (rst)
        rdy && rsv_valid |-> ibuf_space[rsv_warp]);
    a_arr_reserved: assert property (@(posedge clk) disable iff (rst)
        rdy && dec_valid |-> rsv[dec_warp] != '0);
endmodule

// File: tb/tb_gelato_inst_buffer.sv
// tb_gelato_inst_buffer: vector table plus scoreboarded sequences for gelato_inst_buffer
module tb_gelato_inst_buffer;
    logic        clk = 1'b0;
    logic        rst, rdy, rsv_valid, dec_valid, flush_valid, out_valid, out_ready;
    logic [2:0]  rsv_warp, dec_warp, flush_warp, out_warp;
    logic [7:0]  ibuf_space, issue_mask;
    logic [63:0] dec_inst, out_inst;
    int          n_chk, n_fail;
    logic [63:0] model_q [8][$];

    typedef struct {
        logic        rv;
        logic [2:0]  rw;
        logic        dv;
        logic [2:0]  dw;
        logic [63:0] di;
        logic        keep;
        logic [7:0]  mask;
        logic        ordy;
        logic [7:0]  e_space;
        logic        e_ov;
        logic [2:0]  e_ow;
    } vec_t;
    vec_t tv [24];

    always #5 clk = ~clk;

    gelato_inst_buffer dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .rsv_valid(rsv_valid), .rsv_warp(rsv_warp), .ibuf_space(ibuf_space),
        .dec_valid(dec_valid), .dec_warp(dec_warp), .dec_inst(dec_inst),
        .flush_valid(flush_valid), .flush_warp(flush_warp), .issue_mask(issue_mask),
        .out_valid(out_valid), .out_warp(out_warp), .out_inst(out_inst), .out_ready(out_ready)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        rdy = 1'b1;
        rsv_valid = 1'b0;
        dec_valid = 1'b0;
        flush_valid = 1'b0;
        out_ready = 1'b0;
        issue_mask = 8'h00;
    endtask

    function automatic vec_t mk(input logic rv, input logic [2:0] rw, input logic dv, input logic [2:0] dw,
                                input logic [63:0] di, input logic keep, input logic [7:0] mask, input logic ordy,
                                input logic [7:0] e_space, input logic e_ov, input logic [2:0] e_ow);
        vec_t v;
        v.rv = rv; v.rw = rw; v.dv = dv; v.dw = dw; v.di = di; v.keep = keep;
        v.mask = mask; v.ordy = ordy; v.e_space = e_space; v.e_ov = e_ov; v.e_ow = e_ow;
        return v;
    endfunction

    // Every accepted issue must match the oldest expected instruction of that warp.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (model_q[out_warp].size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL issue_unexpected: got warp %0d inst %h expected no issue", out_warp, out_inst);
            end else begin
                chk($sformatf("issue_inst_w%0d", out_warp), out_inst, model_q[out_warp].pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        n_chk = 0;
        n_fail = 0;
        idle_in();
        rst = 1'b1;
        rsv_warp = '0;
        dec_warp = '0;
        flush_warp = '0;
        dec_inst = '0;
        tv[0]  = mk(1, 0, 0, 0, 0, 0, 8'h00, 0, 8'hFF, 0, 0);
        tv[1]  = mk(1, 3, 0, 0, 0, 0, 8'h00, 0, 8'hFF, 0, 0);
        tv[2]  = mk(1, 5, 0, 0, 0, 0, 8'h00, 0, 8'hFF, 0, 0);
        tv[3]  = mk(0, 0, 1, 0, 64'hB000, 1, 8'h00, 0, 8'hFF, 0, 0);
        tv[4]  = mk(0, 0, 1, 3, 64'hB003, 1, 8'h00, 0, 8'hFF, 0, 0);
        tv[5]  = mk(0, 0, 1, 5, 64'hB005, 1, 8'h00, 0, 8'hFF, 0, 0);
        tv[6]  = mk(0, 0, 0, 0, 0, 0, 8'hFF, 1, 8'hFF, 1, 0);
        tv[7]  = mk(0, 0, 0, 0, 0, 0, 8'hFF, 1, 8'hFF, 1, 3);
        tv[8]  = mk(0, 0, 0, 0, 0, 0, 8'hFF, 1, 8'hFF, 1, 5);
        tv[9]  = mk(0, 0, 0, 0, 0, 0, 8'hFF, 1, 8'hFF, 0, 0);
        tv[10] = mk(1, 2, 0, 0, 0, 0, 8'h00, 0, 8'hFF, 0, 0);
        tv[11] = mk(1, 2, 0, 0, 0, 0, 8'h00, 0, 8'hFF, 0, 0);
        tv[12] = mk(1, 2, 0, 0, 0, 0, 8'h00, 0, 8'hFF, 0, 0);
        tv[13] = mk(1, 2, 0, 0, 0, 0, 8'h00, 0, 8'hFF, 0, 0);
        tv[14] = mk(0, 0, 1, 2, 64'hA000, 1, 8'h00, 0, 8'hFB, 0, 0);
        tv[15] = mk(0, 0, 1, 2, 64'hA001, 1, 8'h00, 0, 8'hFB, 0, 0);
        tv[16] = mk(0, 0, 1, 2, 64'hA002, 1, 8'h00, 0, 8'hFB, 0, 0);
        tv[17] = mk(0, 0, 1, 2, 64'hA003, 1, 8'h00, 0, 8'hFB, 0, 0);
        tv[18] = mk(0, 0, 0, 0, 0, 0, 8'h00, 0, 8'hFB, 0, 0);
        tv[19] = mk(0, 0, 0, 0, 0, 0, 8'h04, 1, 8'hFB, 1, 2);
        tv[20] = mk(0, 0, 0, 0, 0, 0, 8'h04, 1, 8'hFF, 1, 2);
        tv[21] = mk(0, 0, 0, 0, 0, 0, 8'h04, 1, 8'hFF, 1, 2);
        tv[22] = mk(0, 0, 0, 0, 0, 0, 8'h04, 1, 8'hFF, 1, 2);
        tv[23] = mk(0, 0, 0, 0, 0, 0, 8'h04, 1, 8'hFF, 0, 0);

        cyc();
        cyc();
        rst = 1'b0;
        #2;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_space", ibuf_space, 8'hFF);
        chk("reset_rr_ptr", dut.rr_ptr, 0);
        cyc();

        for (int i = 0; i < 24; i++) begin
            idle_in();
            rsv_valid = tv[i].rv;
            rsv_warp = tv[i].rw;
            dec_valid = tv[i].dv;
            dec_warp = tv[i].dw;
            dec_inst = tv[i].di;
            issue_mask = tv[i].mask;
            out_ready = tv[i].ordy;
            if (tv[i].dv && tv[i].keep)
                model_q[tv[i].dw].push_back(tv[i].di);
            #2;
            chk($sformatf("vec%0d_space", i), ibuf_space, tv[i].e_space);
            chk($sformatf("vec%0d_out_valid", i), out_valid, tv[i].e_ov);
            if (tv[i].e_ov)
                chk($sformatf("vec%0d_out_warp", i), out_warp, tv[i].e_ow);
            if (i == 18)
                chk("fill_cnt2", dut.cnt[2], 4);
            cyc();
        end

        // Latency: arrival in cycle N is visible in N+1.
        idle_in();
        rsv_valid = 1'b1; rsv_warp = 3'd1;
        cyc();
        idle_in();
        dec_valid = 1'b1; dec_warp = 3'd1; dec_inst = 64'hC001; issue_mask = 8'hFF;
        model_q[1].push_back(64'hC001);
        #2;
        chk("lat_n_out_valid", out_valid, 0);
        cyc();
        idle_in();
        issue_mask = 8'hFF;
        #2;
        chk("lat_n1_out_valid", out_valid, 1);
        chk("lat_n1_out_warp", out_warp, 1);
        out_ready = 1'b1;
        cyc();
        idle_in();
        #2;
        chk("lat_drained", out_valid, 0);

        // Flush warp 4 with two instructions buffered and two in flight.
        idle_in();
        rsv_valid = 1'b1; rsv_warp = 3'd4;
        repeat (4) cyc();
        idle_in();
        dec_valid = 1'b1; dec_warp = 3'd4; dec_inst = 64'hD000;
        model_q[4].push_back(64'hD000);
        cyc();
        dec_inst = 64'hD001;
        model_q[4].push_back(64'hD001);
        cyc();
        idle_in();
        #2;
        chk("flush_pre_space4", ibuf_space[4], 0);
        chk("flush_pre_cnt4", dut.cnt[4], 2);
        flush_valid = 1'b1; flush_warp = 3'd4; issue_mask = 8'hFF;
        #1;
        chk("flush_cycle_out_valid", out_valid, 0);
        model_q[4].delete();
        cyc();
        idle_in();
        dec_valid = 1'b1; dec_warp = 3'd4; dec_inst = 64'hDEAD;
        repeat (2) cyc();
        idle_in();
        issue_mask = 8'hFF;
        #2;
        chk("flush_cnt4", dut.cnt[4], 0);
        chk("flush_drop4", dut.drop[4], 0);
        chk("flush_space4", ibuf_space[4], 1);
        chk("flush_out_valid", out_valid, 0);
        rsv_valid = 1'b1; rsv_warp = 3'd4;
        cyc();
        idle_in();
        dec_valid = 1'b1; dec_warp = 3'd4; dec_inst = 64'hD002;
        model_q[4].push_back(64'hD002);
        cyc();
        idle_in();
        issue_mask = 8'hFF;
        #2;
        chk("flush_new_out_valid", out_valid, 1);
        chk("flush_new_out_warp", out_warp, 4);
        out_ready = 1'b1;
        cyc();
        idle_in();
        #2;
        chk("flush_drained", out_valid, 0);

        // Warp 6 at full credit: simultaneous push and pop, then reads across pointer wrap.
        rsv_valid = 1'b1; rsv_warp = 3'd6;
        repeat (4) cyc();
        idle_in();
        dec_valid = 1'b1; dec_warp = 3'd6;
        for (int i = 0; i < 3; i++) begin
            dec_inst = 64'hE000 + 64'(i);
            model_q[6].push_back(dec_inst);
            cyc();
        end
        idle_in();
        #2;
        chk("pp_pre_cnt6", dut.cnt[6], 3);
        chk("pp_pre_space6", ibuf_space[6], 0);
        dec_valid = 1'b1; dec_warp = 3'd6; dec_inst = 64'hE003;
        model_q[6].push_back(64'hE003);
        issue_mask = 8'hFF; out_ready = 1'b1;
        #1;
        chk("pp_out_valid", out_valid, 1);
        chk("pp_out_warp", out_warp, 6);
        cyc();
        for (int i = 0; i < 4; i++) begin
            idle_in();
            issue_mask = 8'hFF; out_ready = 1'b1;
            if (i == 0) begin
                rsv_valid = 1'b1; rsv_warp = 3'd6;
            end
            if (i == 1) begin
                dec_valid = 1'b1; dec_warp = 3'd6; dec_inst = 64'hE004;
                model_q[6].push_back(64'hE004);
            end
            #2;
            if (i == 0)
                chk("pp_post_cnt6", dut.cnt[6], 3);
            chk($sformatf("pp_drain%0d_out_valid", i), out_valid, 1);
            chk($sformatf("pp_drain%0d_out_warp", i), out_warp, 6);
            cyc();
        end
        idle_in();
        #2;
        chk("pp_drained", out_valid, 0);
        chk("pp_space", ibuf_space, 8'hFF);

        // rdy low for 3 cycles with an arrival, reservation and handshake pending.
        rsv_valid = 1'b1; rsv_warp = 3'd7;
        repeat (2) cyc();
        idle_in();
        dec_valid = 1'b1; dec_warp = 3'd7; dec_inst = 64'hF000;
        model_q[7].push_back(64'hF000);
        cyc();
        idle_in();
        rdy = 1'b0;
        rsv_valid = 1'b1; rsv_warp = 3'd7;
        dec_valid = 1'b1; dec_warp = 3'd7; dec_inst = 64'hF001;
        issue_mask = 8'hFF; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk($sformatf("rdy%0d_out_valid", i), out_valid, 0);
            chk($sformatf("rdy%0d_cnt7", i), dut.cnt[7], 1);
            chk($sformatf("rdy%0d_rsv7", i), dut.rsv[7], 1);
            chk($sformatf("rdy%0d_space", i), ibuf_space, 8'hFF);
            cyc();
        end
        rdy = 1'b1;
        rsv_valid = 1'b0;
        model_q[7].push_back(64'hF001);
        #2;
        chk("rdy_resume_cnt7", dut.cnt[7], 1);
        chk("rdy_resume_rsv7", dut.rsv[7], 1);
        chk("rdy_resume_out_valid", out_valid, 1);
        chk("rdy_resume_out_warp", out_warp, 7);
        cyc();
        idle_in();
        issue_mask = 8'hFF; out_ready = 1'b1;
        #2;
        chk("rdy_second_out_valid", out_valid, 1);
        chk("rdy_second_out_warp", out_warp, 7);
        cyc();
        idle_in();
        #2;
        chk("rdy_drained", out_valid, 0);
        chk("rdy_cnt7", dut.cnt[7], 0);

        // Reset while warp 0 holds an instruction.
        rsv_valid = 1'b1; rsv_warp = 3'd0;
        cyc();
        idle_in();
        dec_valid = 1'b1; dec_warp = 3'd0; dec_inst = 64'h1234;
        cyc();
        idle_in();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        issue_mask = 8'hFF;
        #2;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_space", ibuf_space, 8'hFF);
        chk("midrst_cnt0", dut.cnt[0], 0);
        cyc();

        for (int w = 0; w < 8; w++)
            chk($sformatf("model_empty_w%0d", w), 64'(model_q[w].size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
